// File: rtl/hangman_pkg.sv
// Shared definitions for the Hangman link: ASCII letter bounds and LED FSM states.
package hangman_pkg;

    localparam logic [7:0] UPPER_A     = 8'h41;
    localparam logic [7:0] UPPER_Z     = 8'h5A;
    localparam logic [7:0] LOWER_A     = 8'h61;
    localparam logic [7:0] LOWER_Z     = 8'h7A;
    localparam logic [7:0] CASE_OFFSET = 8'h20;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } led_state_t;

    function automatic logic in_range(input logic [7:0] b, input logic [7:0] lo,
                                      input logic [7:0] hi);
        return (b >= lo) && (b <= hi);
    endfunction

endpackage

// File: rtl/char_fifo.sv
// Synchronous byte FIFO; a push into a full FIFO succeeds only when a pop frees a slot on the same edge.
module char_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       empty,
    output logic       full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // NOTE: storage has no reset; occupancy alone decides what is valid, so stale bytes are never seen.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/msg_rx_reg.sv
// Receive message register: validates UART bytes as guess letters, queues them, and reports link health.
module msg_rx_reg
    import hangman_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int LED_HOLD = 50
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       rx_ready,
    input  logic [7:0] rx_byte,
    input  logic       rx_err,
    input  logic       guess_ack,
    output logic [7:0] guess,
    output logic       guess_valid,
    output logic       red,
    output logic       overflow,
    output logic [3:0] err_cnt
);

    localparam int HOLD_W = (LED_HOLD > 1) ? $clog2(LED_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(LED_HOLD - 1);

    logic              is_upper;
    logic              is_lower;
    logic [7:0]        letter;
    logic              accepted;
    logic              rejected;
    logic              pop;
    logic              dropped;
    logic [7:0]        fifo_rdata;
    logic              fifo_empty;
    logic              fifo_full;
    led_state_t        led_state;
    led_state_t        led_next;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_next;

    assign is_upper = in_range(rx_byte, UPPER_A, UPPER_Z);
    assign is_lower = in_range(rx_byte, LOWER_A, LOWER_Z);
    assign letter   = is_lower ? (rx_byte - CASE_OFFSET) : rx_byte;
    assign accepted = rx_ready && !rx_err && (is_upper || is_lower);
    assign rejected = rx_ready && !accepted;
    assign pop      = guess_valid && guess_ack;
    // A full FIFO only loses the letter when nothing is leaving on the same edge.
    assign dropped  = accepted && fifo_full && !pop;

    char_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .nRst  (nRst),
        .push  (accepted),
        .pop   (pop),
        .wdata (letter),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign guess_valid = !fifo_empty;
    assign guess       = fifo_empty ? 8'h00 : fifo_rdata;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            err_cnt  <= '0;
            overflow <= 1'b0;
        end else begin
            if (rejected && (err_cnt != 4'hF)) err_cnt <= err_cnt + 4'd1;
            if (dropped) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            led_state <= IDLE;
            hold_cnt  <= '0;
        end else begin
            led_state <= led_next;
            hold_cnt  <= hold_next;
        end
    end

    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    always_comb begin
        led_next  = led_state;
        hold_next = hold_cnt;
        case (led_state)
            IDLE: begin
                if (accepted) begin
                    led_next  = HOLD;
                    hold_next = HOLD_LOAD;
                end
            end
            HOLD: begin
                if (accepted) begin
                    hold_next = HOLD_LOAD;
                end else if (hold_cnt == '0) begin
                    led_next = IDLE;
                end else begin
                    hold_next = hold_cnt - HOLD_W'(1);
                end
            end
            default: led_next = IDLE;
        endcase
    end

    assign red = (led_state == HOLD);

endmodule

// File: tb/tb_msg_rx_reg.sv
// Bench for msg_rx_reg: queue-based reference model checked every cycle, plus directed literal checks.
module tb_msg_rx_reg;

    localparam int DEPTH    = 4;
    localparam int LED_HOLD = 50;

    logic       tb_clk = 1'b0;
    logic       nRst;
    logic       rx_ready;
    logic [7:0] rx_byte;
    logic       rx_err;
    logic       guess_ack;
    logic [7:0] guess;
    logic       guess_valid;
    logic       red;
    logic       overflow;
    logic [3:0] err_cnt;

    int tests = 0;
    int fails = 0;
    bit check_en = 1'b0;

    always #5 tb_clk = ~tb_clk;

    msg_rx_reg #(
        .DEPTH    (DEPTH),
        .LED_HOLD (LED_HOLD)
    ) dut (
        .clk         (tb_clk),
        .nRst        (nRst),
        .rx_ready    (rx_ready),
        .rx_byte     (rx_byte),
        .rx_err      (rx_err),
        .guess_ack   (guess_ack),
        .guess       (guess),
        .guess_valid (guess_valid),
        .red         (red),
        .overflow    (overflow),
        .err_cnt     (err_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: letters in a queue, LED as cycles of light remaining.
    logic [7:0] mq[$];
    int         m_err;
    bit         m_ovf;
    int         m_led;
    int         m_n;
    bit         m_acc;
    bit         m_pop;

    function automatic bit is_letter(input logic [7:0] b);
        return (b >= 8'h41 && b <= 8'h5A) || (b >= 8'h61 && b <= 8'h7A);
    endfunction

    function automatic logic [7:0] to_upper(input logic [7:0] b);
        return (b >= 8'h61) ? b - 8'h20 : b;
    endfunction

    always @(posedge tb_clk or negedge nRst) begin
        if (!nRst) begin
            mq.delete();
            m_err = 0;
            m_ovf = 1'b0;
            m_led = 0;
        end else begin
            m_n   = mq.size();
            m_pop = (m_n > 0) && guess_ack;
            m_acc = rx_ready && !rx_err && is_letter(rx_byte);
            if (rx_ready && !m_acc && m_err < 15) m_err++;
            if (m_pop) void'(mq.pop_front());
            if (m_acc) begin
                if (m_n < DEPTH || m_pop) mq.push_back(to_upper(rx_byte));
                else m_ovf = 1'b1;
                m_led = LED_HOLD;
            end else if (m_led > 0) begin
                m_led--;
            end
        end
    end

    always @(negedge tb_clk) begin
        if (check_en) begin
            check("cmp_guess", guess, (mq.size() > 0) ? mq[0] : 8'h00);
            check("cmp_valid", guess_valid, mq.size() > 0);
            check("cmp_red", red, m_led > 0);
            check("cmp_overflow", overflow, m_ovf);
            check("cmp_err_cnt", err_cnt, m_err);
        end
    end

    task automatic tick();
        @(posedge tb_clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic e, input logic a);
        rx_ready  = 1'b1;
        rx_byte   = b;
        rx_err    = e;
        guess_ack = a;
        tick();
        rx_ready  = 1'b0;
        rx_err    = 1'b0;
        guess_ack = 1'b0;
    endtask

    task automatic ack();
        guess_ack = 1'b1;
        tick();
        guess_ack = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_hang [4];
        logic [7:0] exp_full [4];
        int n;
        exp_hang = '{8'h48, 8'h41, 8'h4E, 8'h47};
        exp_full = '{8'h43, 8'h44, 8'h45, 8'h5A};

        nRst      = 1'b0;
        rx_ready  = 1'b0;
        rx_byte   = 8'h00;
        rx_err    = 1'b0;
        guess_ack = 1'b0;
        check_en  = 1'b1;
        tick();
        tick();
        check("rst_guess", guess, 8'h00);
        check("rst_valid", guess_valid, 0);
        check("rst_red", red, 0);
        check("rst_overflow", overflow, 0);
        check("rst_err_cnt", err_cnt, 0);
        nRst = 1'b1;
        tick();

        // Lowercase fold, pop, LED hold length
        send(8'h61, 1'b0, 1'b0);
        check("a_guess", guess, 8'h41);
        check("a_valid", guess_valid, 1);
        check("a_red", red, 1);
        ack();
        check("a_pop_valid", guess_valid, 0);
        check("a_pop_guess", guess, 8'h00);
        repeat (48) tick();
        check("a_red_last", red, 1);
        tick();
        check("a_red_off", red, 0);

        // Rejections and saturation
        send(8'h35, 1'b0, 1'b0);
        send(8'h7B, 1'b0, 1'b0);
        send(8'h48, 1'b1, 1'b0);
        check("bad_err_cnt", err_cnt, 3);
        check("bad_valid", guess_valid, 0);
        check("bad_red", red, 0);
        for (int i = 0; i < 20; i++) send(8'(i), 1'b0, 1'b0);
        check("bad_sat", err_cnt, 15);

        // Fill, overflow, drain
        send(8'h48, 1'b0, 1'b0);
        send(8'h41, 1'b0, 1'b0);
        send(8'h4E, 1'b0, 1'b0);
        send(8'h47, 1'b0, 1'b0);
        check("hang_head", guess, 8'h48);
        check("hang_no_ovf", overflow, 0);
        send(8'h4D, 1'b0, 1'b0);
        check("hang_ovf", overflow, 1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("hang_rd%0d", i), guess, exp_hang[i]);
            ack();
        end
        check("hang_empty", guess_valid, 0);
        check("hang_ovf_sticky", overflow, 1);

        // Reset mid-fill drops contents at once
        send(8'h4A, 1'b0, 1'b0);
        send(8'h4B, 1'b0, 1'b0);
        send(8'h4C, 1'b0, 1'b0);
        check("mid_valid_pre", guess_valid, 1);
        #2 nRst = 1'b0;
        #1;
        check("mid_valid", guess_valid, 0);
        check("mid_guess", guess, 8'h00);
        check("mid_ovf", overflow, 0);
        check("mid_err", err_cnt, 0);
        tick();
        tick();
        nRst = 1'b1;
        tick();
        check("mid_after", guess_valid, 0);

        // Push and pop on the same edge while full
        send(8'h42, 1'b0, 1'b0);
        send(8'h43, 1'b0, 1'b0);
        send(8'h44, 1'b0, 1'b0);
        send(8'h45, 1'b0, 1'b0);
        send(8'h5A, 1'b0, 1'b1);
        check("full_pp_ovf", overflow, 0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("full_rd%0d", i), guess, exp_full[i]);
            ack();
        end
        check("full_empty", guess_valid, 0);

        // Push and pop with a single entry
        send(8'h51, 1'b0, 1'b0);
        check("one_q", guess, 8'h51);
        send(8'h52, 1'b0, 1'b1);
        check("one_r", guess, 8'h52);
        check("one_valid", guess_valid, 1);
        ack();

        // Classification boundaries; inputs ignored without rx_ready
        send(8'h40, 1'b0, 1'b0);
        send(8'h5B, 1'b0, 1'b0);
        send(8'h60, 1'b0, 1'b0);
        send(8'h7B, 1'b0, 1'b0);
        check("bnd_err", err_cnt, 4);
        check("bnd_valid", guess_valid, 0);
        send(8'h7A, 1'b0, 1'b0);
        check("bnd_z", guess, 8'h5A);
        ack();
        rx_byte = 8'h41;
        rx_err  = 1'b1;
        tick();
        rx_err = 1'b0;
        check("idle_valid", guess_valid, 0);
        check("idle_err", err_cnt, 4);

        // LED retriggered by letters 10 cycles apart
        n = 0;
        while (red && n < 200) begin
            tick();
            n++;
        end
        check("led_wait_timeout", red, 0);
        for (int i = 0; i < 3; i++) begin
            send(8'h6C, 1'b0, 1'b0);
            ack();
            if (i < 2) repeat (8) tick();
        end
        repeat (48) tick();
        check("spaced_red_last", red, 1);
        tick();
        check("spaced_red_off", red, 0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/msg_rx_reg.md
Name: msg_rx_reg

Overview:
Receive-side counterpart of the transmit message register. It accepts bytes strobed out of the UART receiver and validates them as Hangman guess letters, folding lowercase to uppercase. Accepted letters are buffered in a small FIFO and presented to the game logic over a valid/ack handshake. A red activity LED, an overflow flag and an error counter report link health.

Parameters:
DEPTH, 4, number of guess-letter FIFO entries (power of 2, >= 2)
LED_HOLD, 50, clock cycles the red LED stays lit after an accepted letter (>= 1)

Ports:
clk  input  1  system clock, rising-edge
nRst  input  1  asynchronous active-low reset
rx_ready  input  1  one-cycle strobe from UART receiver: rx_byte/rx_err valid this cycle
rx_byte  input  8  received byte
rx_err  input  1  framing/parity error qualifier, sampled only with rx_ready
guess_ack  input  1  game logic consumed current guess
guess  output  8  head-of-FIFO letter, uppercase ASCII
guess_valid  output  1  FIFO not empty
red  output  1  receive-activity LED
overflow  output  1  sticky: an accepted letter was dropped because the FIFO was full
err_cnt  output  4  saturating count of rejected bytes

Behaviour:
- Interface as decided: one clock (clk); reset nRst is asynchronous, active-low.
- Reset values: guess=8'h00, guess_valid=0, red=0, overflow=0, err_cnt=0. FIFO pointers and occupancy cleared, LED FSM in IDLE.
- Reset asserted mid-operation discards all buffered letters immediately.
- Classification happens on the rising edge where rx_ready=1:
  - rx_err=1: drop the byte; err_cnt+1.
  - 0x41-0x5A: accept unchanged.
  - 0x61-0x7A: accept as rx_byte-0x20.
  - Any other value: drop; err_cnt+1.
  - err_cnt saturates at 15 and clears only on reset.
  - rx_byte and rx_err are ignored when rx_ready=0.
- Push: an accepted letter is written on the same edge.
  - If the FIFO was empty, guess_valid=1 and guess=letter in the following cycle, i.e. 1-cycle latency, registered outputs.
- Output handshake:
  - guess_valid = !empty; guess = head entry.
  - guess=8'h00 when empty.
  - Pop on a rising edge with guess_valid & guess_ack.
  - guess_ack while guess_valid=0 is ignored.
  - guess is held stable until popped.
- Full FIFO:
  - An accepted letter arriving while full, with no pop on the same edge, is dropped and sets overflow (sticky until reset).
  - Push and pop on the same edge while full: both occur, no overflow.
  - Push and pop on the same edge with 1 entry: the head advances to the new letter and guess_valid stays 1.
- Pointers wrap modulo DEPTH. Occupancy counter width is clog2(DEPTH+1).
- LED FSM, states IDLE and HOLD:
  - IDLE -> HOLD on an accepted letter (pushed or overflow-dropped); load hold_cnt=LED_HOLD-1.
  - HOLD: red=1. hold_cnt decrements each cycle; at 0, return to IDLE.
  - An accepted letter while in HOLD reloads hold_cnt.
  - red is registered: it rises the cycle after acceptance and stays high exactly LED_HOLD cycles after the last accepted letter.
  - Rejected bytes do not affect the LED.

Decomposition:
- Shared package hangman_pkg holds:
  - ASCII bounds UPPER_A=8'h41, UPPER_Z=8'h5A, LOWER_A=8'h61, LOWER_Z=8'h7A, CASE_OFFSET=8'h20.
  - typedef enum led_state_t {IDLE, HOLD}.
- One sub-module, char_fifo: synchronous FIFO, parameter DEPTH, 8-bit data.
  - Ports: push, pop, wdata, rdata, empty, full.
- Classification and LED FSM live in msg_rx_reg.

Test Plan:
- Reset with nRst low for 2 cycles -> all outputs 0, guess=8'h00; assert nRst mid-FIFO-fill with 3 entries -> guess_valid=0 at once, contents lost.
- rx_ready pulse with rx_byte=8'h61 ('a') -> next cycle guess=8'h41, guess_valid=1, red=1. guess_ack for 1 cycle -> guess_valid=0, guess=8'h00. red stays 1 for 50 cycles, then 0.
- Bytes 8'h35, 8'h7B, and 8'h48 with rx_err=1 -> nothing queued, err_cnt=3, red stays 0. Then 20 more bad bytes -> err_cnt=15 (saturated).
- Push 'H','A','N','G' with no ack -> guess='H', 4 entries. Push 'M' -> dropped, overflow=1. Ack 4 times -> reads H,A,N,G, then guess_valid=0; overflow stays 1.
- With FIFO full, rx_ready 'Z' and guess_ack on the same edge -> overflow stays 0 and 'Z' is read last after the remaining 3. With one entry 'Q', push 'R' plus ack -> guess='R', guess_valid=1.
- Letters 10 cycles apart -> red held continuously, falling exactly 50 cycles after the last letter.
